dense_to_csr_encoder: RTL and testbench
=======================================

Name: dense_to_csr_encoder

Overview:
- Upstream loader for the sparse matrix-multiply core.
- Accepts a dense matrix streamed row-major, one 32-bit element per handshake.
- Builds the CSR triple that the multiply core consumes: non-zero values NV, column indices CI and row pointers RP.
- One instance per operand (A and B); its outputs connect directly to the core's NV*/CI*/RP* inputs.

Parameters:
- DATA_W, 32, width of a matrix element.
- MAX_ELEM, 16, entries per CSR array.
- IDX_W, 4, width of CI/RP entries and of row/nnz counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin a new encode; sampled only in IDLE.
- rows_i  in  IDX_W  row count, 0..15; latched on start.
- cols_i  in  IDX_W+1  column count, 0..16; latched on start; values >16 clamp to 16.
- elem_valid_i  in  1  element valid.
- elem_data_i  in  DATA_W  element value.
- elem_ready_o  out  1  element accepted when valid&&ready.
- NV_o  out  MAX_ELEM x DATA_W  non-zero values, packed from index 0.
- CI_o  out  MAX_ELEM x IDX_W  column index of each NV entry.
- RP_o  out  MAX_ELEM x IDX_W  row pointers; RP[0]=0, RP[r+1]=nnz after row r.
- nnz_o  out  IDX_W  stored non-zero count.
- busy_o  out  1  high in LOAD.
- done_o  out  1  arrays valid and stable.
- overflow_o  out  1  at least one non-zero dropped.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - State goes to IDLE.
  - All array entries, nnz_o, busy_o, done_o, overflow_o and elem_ready_o go to 0.
  - Internal row counter, column counter and latched dims go to 0.
  - Reset dominates every other input in the same cycle.
  - Reset mid-LOAD abandons the matrix; the remainder of the stream is not consumed.
- States:
  - IDLE: elem_ready_o=0. On start_i:
    - clear NV/CI/RP, nnz, overflow and done;
    - latch rows and clamped cols;
    - if rows==0 or cols==0, go to DONE;
    - otherwise go to LOAD with row=0, col=0.
  - LOAD: elem_ready_o=1, busy_o=1. On each accept:
    - if data!=0 and nnz<15: NV[nnz]<=data, CI[nnz]<=col, nnz<=nnz+1;
    - if data!=0 and nnz==15: element dropped, overflow_o<=1 (sticky until next start/reset);
    - zero elements are never stored.
    - if col==cols-1: col<=0, RP[row+1]<=post-accept nnz (includes the current element if stored), row<=row+1;
    - otherwise col<=col+1.
    - Accept of the last element of the last row goes to DONE.
    - Cycles with no accept hold all state.
  - DONE: done_o=1, busy_o=0, elem_ready_o=0; arrays frozen. start_i returns to the IDLE start actions in the same cycle (clear and latch), i.e. direct re-start.
- Capacity:
  - nnz is limited to 15 so that every RP value fits in IDX_W bits.
  - rows ≤15 so that rows+1 RP entries fit in MAX_ELEM.
  - RP entries beyond index rows stay 0.
- Latency:
  - Array entries update on the edge that accepts the element.
  - done_o rises on the edge accepting the final element, i.e. visible the cycle after the final handshake.
  - Total cycles from start to done = 1 + rows*cols when valid is held high.
- start_i during LOAD is ignored.
- elem_valid_i outside LOAD is ignored (not accepted).
- Equality check `data!=0` is on the full DATA_W bits.

Test Plan:
- 3x3 matrix [[1,0,2],[0,0,0],[0,3,0]], valid held high -> NV=[1,2,3,0..], CI=[0,2,1,0..], RP=[0,2,2,3,0..], nnz_o=3, overflow_o=0, done_o high 10 cycles after start edge.
- Same matrix with elem_valid_i toggling every other cycle -> identical arrays; done_o only after 9th accept; no element accepted while valid low.
- 4x4 all-ones -> first 15 stored with CI=0,1,2,3,0..., 16th dropped, overflow_o=1, nnz_o=15, RP=[0,4,8,12,15].
- start_i with rows_i=0 (and separately cols_i=0) -> DONE next cycle, elem_ready_o never high, all arrays 0, nnz_o=0.
- rst_i asserted after 5 accepts of a 3x3 load -> next cycle all outputs 0, IDLE; a new start with 2x2 [[0,7],[5,0]] gives NV=[7,5], CI=[1,0], RP=[0,1,2].
- start_i pulsed mid-LOAD -> ignored, arrays of current matrix unaffected; start_i in DONE -> arrays cleared and new load begins.

Source files
------------

// File: rtl/dense_to_csr_encoder.sv
// Dense row-major matrix stream to CSR (NV/CI/RP) encoder feeding the sparse multiply core.
// Arrays are written in place as elements are accepted and held frozen once done_o rises.
module dense_to_csr_encoder #(
  parameter int DATA_W   = 32,
  parameter int MAX_ELEM = 16,
  parameter int IDX_W    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [IDX_W-1:0]                 rows_i,
  input  logic [IDX_W:0]                   cols_i,
  input  logic                             elem_valid_i,
  input  logic [DATA_W-1:0]                elem_data_i,
  output logic                             elem_ready_o,
  output logic [MAX_ELEM-1:0][DATA_W-1:0]  NV_o,
  output logic [MAX_ELEM-1:0][IDX_W-1:0]   CI_o,
  output logic [MAX_ELEM-1:0][IDX_W-1:0]   RP_o,
  output logic [IDX_W-1:0]                 nnz_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // nnz saturates one below MAX_ELEM so every row pointer fits in IDX_W bits
  localparam logic [IDX_W-1:0] NNZ_MAX = IDX_W'(MAX_ELEM - 1);
  localparam logic [IDX_W:0]   COL_MAX = (IDX_W+1)'(MAX_ELEM);
  localparam logic [IDX_W:0]   COL_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] ROW_ONE = IDX_W'(1);

  logic [1:0]       state_q;
  logic [IDX_W-1:0] rows_q, row_q;
  logic [IDX_W:0]   cols_q, col_q;

  logic             start_ok, accept, nonzero, store, drop, last_col, last_row;
  logic [IDX_W:0]   cols_clamped;
  logic [IDX_W-1:0] nnz_nxt;

  always_comb begin
    start_ok     = start_i && (state_q != S_LOAD);
    accept       = (state_q == S_LOAD) && elem_valid_i;
    nonzero      = (elem_data_i != '0);
    store        = accept && nonzero && (nnz_o != NNZ_MAX);
    drop         = accept && nonzero && (nnz_o == NNZ_MAX);
    nnz_nxt      = nnz_o + {{(IDX_W-1){1'b0}}, store};
    last_col     = (col_q == cols_q - COL_ONE);
    last_row     = (row_q == rows_q - ROW_ONE);
    cols_clamped = (cols_i > COL_MAX) ? COL_MAX : cols_i;
  end

  assign elem_ready_o = (state_q == S_LOAD);
  assign busy_o       = (state_q == S_LOAD);
  assign done_o       = (state_q == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      NV_o       <= '0;
      CI_o       <= '0;
      RP_o       <= '0;
      nnz_o      <= '0;
      overflow_o <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (start_ok) begin
      NV_o       <= '0;
      CI_o       <= '0;
      RP_o       <= '0;
      nnz_o      <= '0;
      overflow_o <= 1'b0;
      rows_q     <= rows_i;
      cols_q     <= cols_clamped;
      row_q      <= '0;
      col_q      <= '0;
      state_q    <= (rows_i == '0 || cols_clamped == '0) ? S_DONE : S_LOAD;
    end else if (accept) begin
      if (store) begin
        NV_o[nnz_o] <= elem_data_i;
        CI_o[nnz_o] <= col_q[IDX_W-1:0];
        nnz_o       <= nnz_nxt;
      end
      if (drop) overflow_o <= 1'b1;
      // row pointer carries the post-accept count, so it includes this element if stored
      if (last_col) begin
        col_q                <= '0;
        RP_o[row_q + ROW_ONE] <= nnz_nxt;
        row_q                <= row_q + ROW_ONE;
        if (last_row) state_q <= S_DONE;
      end else begin
        col_q <= col_q + COL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dense_to_csr_encoder.sv
// Table-driven bench for dense_to_csr_encoder; expected CSR results go through a scoreboard queue.
module tb_dense_to_csr_encoder;
  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  start_i;
  logic [3:0]            rows_i;
  logic [4:0]            cols_i;
  logic                  elem_valid_i;
  logic [31:0]           elem_data_i;
  logic                  elem_ready_o;
  logic [15:0][31:0]     NV_o;
  logic [15:0][3:0]      CI_o;
  logic [15:0][3:0]      RP_o;
  logic [3:0]            nnz_o;
  logic                  busy_o, done_o, overflow_o;

  dense_to_csr_encoder #(.DATA_W(32), .MAX_ELEM(16), .IDX_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
    .elem_valid_i(elem_valid_i), .elem_data_i(elem_data_i), .elem_ready_o(elem_ready_o),
    .NV_o(NV_o), .CI_o(CI_o), .RP_o(RP_o), .nnz_o(nnz_o),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string            name;
    logic [3:0]       rows;
    logic [4:0]       cols;
    int               n;          // elements the bench streams (rows * clamped cols)
    bit               toggle;     // valid high every other cycle
    bit               mid_start;  // pulse start_i during LOAD
    int               exp_edges;  // clock edges from start edge until done_o visible
    logic [15:0][31:0] m;
    logic [15:0][31:0] nv;
    logic [15:0][3:0]  ci;
    logic [15:0][3:0]  rp;
    logic [3:0]        nnz;
    logic              ovf;
  } vec_t;

  vec_t tbl[8];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input int r, input int c, input int n, input int edges);
    vec_t v;
    v.name = nm; v.rows = 4'(r); v.cols = 5'(c); v.n = n;
    v.toggle = 1'b0; v.mid_start = 1'b0; v.exp_edges = edges;
    v.m = '0; v.nv = '0; v.ci = '0; v.rp = '0; v.nnz = '0; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   idx, edges, cyc;
    bit   vld, acc;
    @(negedge clk_i);
    start_i = 1'b1; rows_i = v.rows; cols_i = v.cols; elem_valid_i = 1'b0;
    sb_q.push_back(v);
    @(posedge clk_i); edges = 1;
    @(negedge clk_i); start_i = 1'b0;
    chk({v.name, " start_nnz"}, nnz_o, 0);
    chk({v.name, " start_done"}, done_o, v.n == 0);
    chk({v.name, " start_busy"}, busy_o, v.n != 0);
    chk({v.name, " start_ready"}, elem_ready_o, v.n != 0);
    idx = 0; cyc = 0;
    while (!done_o && edges < 400) begin
      vld = v.toggle ? (cyc % 2 == 0) : 1'b1;
      elem_valid_i = vld;
      elem_data_i  = (idx < 16) ? v.m[idx] : 32'hdead_beef;
      if (v.mid_start && idx == 4) begin
        start_i = 1'b1; rows_i = 4'd2; cols_i = 5'd2;
      end
      acc = vld && elem_ready_o;
      @(posedge clk_i); edges++; cyc++;
      if (acc) idx++;
      @(negedge clk_i); start_i = 1'b0; elem_valid_i = 1'b0;
    end
    if (!done_o) begin
      checks++; errors++;
      $display("FAIL %s timeout: done_o still 0 after %0d edges, required 1", v.name, edges);
    end
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: queue empty, required one entry", v.name);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, " accepts"}, idx, e.n);
      chk({e.name, " edges"}, edges, e.exp_edges);
      chk({e.name, " NV"}, NV_o, e.nv);
      chk({e.name, " CI"}, CI_o, e.ci);
      chk({e.name, " RP"}, RP_o, e.rp);
      chk({e.name, " nnz"}, nnz_o, e.nnz);
      chk({e.name, " ovf"}, overflow_o, e.ovf);
      chk({e.name, " busy"}, busy_o, 0);
      chk({e.name, " ready"}, elem_ready_o, 0);
      // valid in DONE must not disturb frozen arrays
      elem_valid_i = 1'b1; elem_data_i = 32'h55;
      @(posedge clk_i); @(negedge clk_i); elem_valid_i = 1'b0;
      chk({e.name, " frozen_nnz"}, nnz_o, e.nnz);
      chk({e.name, " frozen_NV"}, NV_o, e.nv);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rows_i = '0; cols_i = '0;
    elem_valid_i = 1'b0; elem_data_i = '0;

    tbl[0] = mk("m3x3", 3, 3, 9, 10);
    tbl[0].m[0] = 1; tbl[0].m[2] = 2; tbl[0].m[7] = 3;
    tbl[0].nv[0] = 1; tbl[0].nv[1] = 2; tbl[0].nv[2] = 3;
    tbl[0].ci[0] = 0; tbl[0].ci[1] = 2; tbl[0].ci[2] = 1;
    tbl[0].rp[1] = 2; tbl[0].rp[2] = 2; tbl[0].rp[3] = 3;
    tbl[0].nnz = 3;

    tbl[1] = tbl[0]; tbl[1].name = "m3x3_toggle"; tbl[1].toggle = 1'b1; tbl[1].exp_edges = 18;

    tbl[2] = mk("ones4x4", 4, 4, 16, 17);
    for (int k = 0; k < 16; k++) tbl[2].m[k] = 1;
    for (int k = 0; k < 15; k++) begin tbl[2].nv[k] = 1; tbl[2].ci[k] = 4'(k % 4); end
    tbl[2].rp[1] = 4; tbl[2].rp[2] = 8; tbl[2].rp[3] = 12; tbl[2].rp[4] = 15;
    tbl[2].nnz = 15; tbl[2].ovf = 1'b1;

    tbl[3] = mk("m2x2", 2, 2, 4, 5);
    tbl[3].m[1] = 7; tbl[3].m[2] = 5;
    tbl[3].nv[0] = 7; tbl[3].nv[1] = 5; tbl[3].ci[0] = 1; tbl[3].ci[1] = 0;
    tbl[3].rp[1] = 1; tbl[3].rp[2] = 2; tbl[3].nnz = 2;

    // cols_i=20 clamps to 16; MSB-only element proves the full-width zero test
    tbl[4] = mk("row1x20", 1, 20, 16, 17);
    tbl[4].m[0] = 32'h8000_0000;
    for (int k = 1; k < 16; k++) tbl[4].m[k] = k + 1;
    tbl[4].nv[0] = 32'h8000_0000; tbl[4].ci[0] = 0;
    for (int k = 1; k < 15; k++) begin tbl[4].nv[k] = k + 1; tbl[4].ci[k] = 4'(k); end
    tbl[4].rp[1] = 15; tbl[4].nnz = 15; tbl[4].ovf = 1'b1;

    tbl[5] = mk("rows0", 0, 3, 0, 1);
    tbl[6] = mk("cols0", 2, 0, 0, 1);
    tbl[7] = tbl[0]; tbl[7].name = "m3x3_midstart"; tbl[7].mid_start = 1'b1;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst NV", NV_o, 0);
    chk("rst RP", RP_o, 0);
    chk("rst nnz", nnz_o, 0);
    chk("rst flags", {busy_o, done_o, overflow_o, elem_ready_o}, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // reset after 5 accepts abandons the matrix
    @(negedge clk_i);
    start_i = 1'b1; rows_i = 4'd3; cols_i = 5'd3;
    @(posedge clk_i); @(negedge clk_i); start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      elem_valid_i = 1'b1; elem_data_i = tbl[0].m[k];
      @(posedge clk_i); @(negedge clk_i);
    end
    chk("pre_rst nnz", nnz_o, 2);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst NV", NV_o, 0);
    chk("midrst CI", CI_o, 0);
    chk("midrst RP", RP_o, 0);
    chk("midrst nnz", nnz_o, 0);
    chk("midrst flags", {busy_o, done_o, overflow_o, elem_ready_o}, 0);
    @(posedge clk_i); @(negedge clk_i);
    elem_valid_i = 1'b0;
    chk("idle ignores valid", nnz_o, 0);
    run_vec(tbl[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
